uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single uart transmitter between N byte sources.
//   - Round-robin arbitration between requesters.
//   - Launches each byte with a one-cycle transmit pulse.
//   - Tracks busy_tx through the full frame.
//   - Optionally locks the grant for a multi-byte packet.
//   - Sits between the debug/status producers and uart.tx.
// PARAMETERS
//   N            4    number of requesters (2..8)
//   GAP          0    idle clk cycles inserted after busy_tx falls, before next launch (0..255)
//   BUSY_TIMEOUT 15   clk cycles allowed for busy_tx to rise after launch (1..255)
// PORTS
//   clk           in   1     system clock, all logic on rising edge
//   rst           in   1     synchronous reset, active-high
//   req_valid     in   N     requester i has a byte; hold with data/last until req_ready[i]
//   req_data      in   8N    byte of requester i at [8i+7:8i]
//   req_last      in   N     byte of requester i ends its packet (used only with lock)
//   req_ready     out  N     one-cycle pulse: byte of requester i accepted
//   grant         out  N     one-hot owner of last launch; 0 before first launch
//   uart_transmit out  1     to uart.transmit, one-cycle pulse
//   uart_data_tx  out  8     to uart.data_tx, held stable from launch until next launch
//   uart_busy_tx  in   1     from uart.busy_tx
//   err_timeout   out  1     one-cycle pulse: busy_tx failed to rise in time, byte dropped
// BEHAVIOUR
//   Reset (rst=1 at edge)
//     - All outputs 0; state IDLE; rr pointer=N-1; lock cleared; counters 0.
//     - Reset mid-frame only abandons tracking; uart finishes its frame independently.
//   States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
//   IDLE
//     - Eligible set: req_valid, masked to the locked owner when lock is active.
//     - Launch only if eligible set nonzero and uart_busy_tx=0.
//     - Winner w: first eligible index after rr pointer, searching upward with wrap N-1 -> 0.
//     - At the launch edge: uart_data_tx<=req_data[w]; uart_transmit<=1; req_ready[w]<=1;
//       grant<=1<<w; rr<=w; timeout count<=0; next state WAIT_BUSY.
//     - Latency: valid seen in cycle t -> uart_transmit and req_ready high in cycle t+1.
//   uart_transmit and req_ready
//     - Forced to 0 on the edge after launch, so each is exactly one cycle wide.
//   WAIT_BUSY
//     - uart_busy_tx=1 -> WAIT_DONE.
//     - Else count increments. When count==BUSY_TIMEOUT: err_timeout pulse, lock cleared, -> IDLE.
//   WAIT_DONE
//     - uart_busy_tx=0 -> GAP if GAP>0, else IDLE.
//     - Next launch cannot occur before the cycle after busy_tx is seen low.
//   GAP
//     - Counts GAP cycles, then -> IDLE.
//   Simultaneous requests
//     - Exactly one winner per launch.
//     - A requester is never granted twice while another valid requester waits (lock off).
//   req_valid dropped before ready
//     - Legal; that requester simply leaves the eligible set.
//   N=1
//     - Degenerates to a pass-through sequencer; rr logic is constant.
// CONFIGURATION
//   UART_ARB_LOCK_EN defined
//     - A launched byte with req_last[w]=0 sets lock to w.
//     - Only requester w is eligible until a byte with req_last=1 is launched
//       (lock clears at that launch) or a timeout occurs.
//     - Other requesters wait indefinitely; no lock timeout.
//   UART_ARB_LOCK_EN undefined
//     - req_last ignored; arbitration is per byte.
// TESTING
//   1. Single source: req_valid=0001, data 0x55; uart model raises busy 1 cycle after transmit,
//      frame 10 bauds -> one transmit pulse, data_tx=0x55, req_ready[0] 1 cycle, grant=0001.
//   2. All four valid from reset, data 0xA0..0xA3 held -> launch order 0,1,2,3,0;
//      no launch while busy_tx=1.
//   3. GAP=5 -> exactly 5 idle cycles between busy_tx fall and next uart_transmit.
//   4. uart model never raises busy, BUSY_TIMEOUT=15 -> err_timeout 15 cycles after launch,
//      back to IDLE, next request served.
//   5. LOCK_EN: req0 sends 3 bytes (last on 3rd) while req1 valid
//      -> bytes 0,0,0 then req1; without LOCK_EN -> 0,1,0,1.
//   6. rst asserted in WAIT_DONE -> next cycle all outputs 0, grant 0; after release,
//      launch waits for busy_tx=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N byte sources.
// Define UART_ARB_LOCK_EN to hold the grant for multi-byte packets (req_last).
module uart_tx_arbiter #(
    parameter int N            = 4,
    parameter int GAP          = 0,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           uart_transmit,
    output logic [7:0]     uart_data_tx,
    input  logic           uart_busy_tx,
    output logic           err_timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [7:0]    TO_LAST  = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]    GAP_LAST = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic [PW-1:0] RR_INIT  = PW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [7:0]    tcnt_q, tcnt_d;
    logic [7:0]    gcnt_q, gcnt_d;
    logic [7:0]    data_q, data_d;
    logic          xmit_q, xmit_d;
    logic [N-1:0]  ready_q, ready_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          err_q, err_d;

    logic [N-1:0]  elig;
    logic          win_vld;
    logic [PW-1:0] win_idx;
    logic          launch;
    logic          tmo;

`ifdef UART_ARB_LOCK_EN
    logic          lock_q, lock_d;
    logic [PW-1:0] owner_q, owner_d;

    assign elig = lock_q ? (req_valid & (N'(1) << owner_q)) : req_valid;

    // Lock follows the last launched byte; a timeout always releases it.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (launch) begin
            lock_d  = !req_last[win_idx];
            owner_d = win_idx;
        end else if (tmo) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig        = req_valid;
`endif

    // First eligible index strictly after the rr pointer, wrapping.
    always_comb begin
        int c;
        c       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(rr_q) + k) % N;
            if (!win_vld && elig[c]) begin
                win_vld = 1'b1;
                win_idx = PW'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        tcnt_d  = tcnt_q;
        gcnt_d  = gcnt_q;
        data_d  = data_q;
        grant_d = grant_q;
        xmit_d  = 1'b0;
        ready_d = '0;
        launch  = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld && !uart_busy_tx) begin
                    launch  = 1'b1;
                    data_d  = req_data[8*int'(win_idx) +: 8];
                    xmit_d  = 1'b1;
                    ready_d = N'(1) << win_idx;
                    grant_d = N'(1) << win_idx;
                    rr_d    = win_idx;
                    tcnt_d  = '0;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (uart_busy_tx) begin
                    state_d = S_WAIT_DONE;
                end else if (tcnt_q == TO_LAST) begin
                    tmo     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy_tx) begin
                    gcnt_d  = '0;
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        err_d = tmo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= RR_INIT;
            tcnt_q  <= '0;
            gcnt_q  <= '0;
            data_q  <= '0;
            xmit_q  <= 1'b0;
            ready_q <= '0;
            grant_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            tcnt_q  <= tcnt_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            xmit_q  <= xmit_d;
            ready_q <= ready_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    assign req_ready     = ready_q;
    assign grant         = grant_q;
    assign uart_transmit = xmit_q;
    assign uart_data_tx  = data_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple uart busy model.
// Directed steps cover reset, rr order, gap, timeout, packet lock and mid-frame reset.
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int TB_GAP = 5;
    localparam int TO     = 15;
    localparam int FRAME  = 10;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       last;
    } src_t;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           uart_transmit;
    logic [7:0]     uart_data_tx;
    logic           uart_busy_tx;
    logic           err_timeout;

    int   cyc = 0;
    int   busy_cnt = 0;
    bit   model_en;
    int   checks = 0;
    int   errors = 0;
    int   fall_cyc = -1;
    bit   prev_busy = 1'b0;
    bit   was_tx = 1'b0;
    bit   lat_chk = 1'b0;
    bit   gap_chk = 1'b0;
    int   pres_cyc [N];
    src_t src_q[$];
    exp_t exp_q[$];

    uart_tx_arbiter #(
        .N(N),
        .GAP(TB_GAP),
        .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .uart_transmit(uart_transmit),
        .uart_data_tx(uart_data_tx),
        .uart_busy_tx(uart_busy_tx),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy rises the cycle after transmit and lasts FRAME cycles.
    always @(posedge clk) begin
        if (uart_transmit && model_en) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign uart_busy_tx = (busy_cnt != 0);

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_src(input int i, input logic [7:0] d, input logic l);
        src_t s;
        s.idx  = i;
        s.data = d;
        s.last = l;
        src_q.push_back(s);
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One cycle: sample at negedge, score launches, then update sources.
    task automatic tick();
        exp_t e;
        bit   found;
        @(negedge clk);
        if (rst) begin
            fall_cyc = -1;
            was_tx   = 1'b0;
        end else begin
            if (was_tx) begin
                check("xmit_width", uart_transmit, 0);
                check("ready_width", req_ready, 0);
            end
            if (uart_transmit) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant", grant, 1 << e.idx);
                    check("data_tx", uart_data_tx, e.data);
                    check("req_ready", req_ready, 1 << e.idx);
                    check("busy_at_launch", prev_busy, 0);
                    if (lat_chk) check("latency", cyc - pres_cyc[e.idx], 1);
                    if (gap_chk && fall_cyc >= 0)
                        check("gap", cyc - fall_cyc, TB_GAP + 2);
                end
                fall_cyc = -1;
            end else if (!was_tx) begin
                check("ready_no_xmit", req_ready, 0);
            end
            if (prev_busy && !uart_busy_tx) fall_cyc = cyc;
            was_tx = uart_transmit;
        end
        prev_busy = uart_busy_tx;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) req_valid[i] = 1'b0;
            if (!req_valid[i]) begin
                found = 1'b0;
                for (int k = 0; k < src_q.size(); k++) begin
                    if (!found && src_q[k].idx == i) begin
                        found            = 1'b1;
                        req_data[8*i +: 8] = src_q[k].data;
                        req_last[i]      = src_q[k].last;
                        req_valid[i]     = 1'b1;
                        pres_cyc[i]      = cyc;
                        src_q.delete(k);
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check("drain", n < 400, 1);
        repeat (FRAME + TB_GAP + 4) tick();
        check("valid_left", req_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int te;
        rst       = 1'b1;
        model_en  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) tick();
        check("rst_xmit", uart_transmit, 0);
        check("rst_ready", req_ready, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err_timeout, 0);
        check("rst_data", uart_data_tx, 0);
        rst = 1'b0;

        // single source
        lat_chk = 1'b1;
        push_src(0, 8'h55, 1'b1);
        push_exp(0, 8'h55);
        drain();
        lat_chk = 1'b0;

        // all four valid from reset, round-robin order
        for (int i = 0; i < N; i++) push_src(i, 8'hA0 + 8'(i), 1'b1);
        push_src(0, 8'hA4, 1'b1);
        do_reset();
        gap_chk = 1'b1;
        for (int i = 0; i < N; i++) push_exp(i, 8'hA0 + 8'(i));
        push_exp(0, 8'hA4);
        drain();

        // packet: req0 three bytes, req1 two bytes
        do_reset();
        push_src(0, 8'hB0, 1'b0);
        push_src(0, 8'hB1, 1'b0);
        push_src(0, 8'hB2, 1'b1);
        push_src(1, 8'hC0, 1'b1);
        push_src(1, 8'hC1, 1'b1);
`ifdef UART_ARB_LOCK_EN
        push_exp(0, 8'hB0);
        push_exp(0, 8'hB1);
        push_exp(0, 8'hB2);
        push_exp(1, 8'hC0);
        push_exp(1, 8'hC1);
`else
        push_exp(0, 8'hB0);
        push_exp(1, 8'hC0);
        push_exp(0, 8'hB1);
        push_exp(1, 8'hC1);
        push_exp(0, 8'hB2);
`endif
        drain();
        gap_chk = 1'b0;

        // uart never goes busy: timeout
        model_en = 1'b0;
        t0 = -1;
        te = -1;
        push_src(2, 8'h3C, 1'b1);
        push_exp(2, 8'h3C);
        for (int n = 0; n < 60 && te < 0; n++) begin
            tick();
            if (uart_transmit) t0 = cyc;
            if (err_timeout) te = cyc;
        end
        check("timeout_seen", te >= 0, 1);
        check("timeout_delay", te - t0, TO);
        tick();
        check("timeout_width", err_timeout, 0);
        model_en = 1'b1;
        push_src(3, 8'h77, 1'b1);
        push_exp(3, 8'h77);
        drain();

        // reset while the frame is in flight
        push_src(0, 8'hD0, 1'b1);
        push_exp(0, 8'hD0);
        for (int n = 0; n < 20 && !uart_busy_tx; n++) tick();
        check("busy_seen", uart_busy_tx, 1);
        tick();
        tick();
        push_src(1, 8'hE1, 1'b1);
        push_exp(1, 8'hE1);
        rst = 1'b1;
        tick();
        check("midrst_xmit", uart_transmit, 0);
        check("midrst_ready", req_ready, 0);
        check("midrst_grant", grant, 0);
        check("midrst_err", err_timeout, 0);
        check("midrst_data", uart_data_tx, 0);
        check("midrst_busy", uart_busy_tx, 1);
        rst = 1'b0;
        drain();
        check("exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
